mips_tb_run_monitor: RTL and testbench

Bench-side run monitor sitting directly downstream of `mips_cpu_harvard`, consuming its `active`, `instr_address` and `register_v0` outputs. Tracks a program run from reset vector to halt, counts enabled cycles and fetches, and enforces a timeout watchdog. On completion it latches the final `register_v0` and compares it against an expected value. It replaces the ad-hoc negedge halt check in each directed test with one reusable, registered verdict.

---
 rtl/mips_tb_pkg.sv | 24 ++
 rtl/mips_tb_sat_counter.sv | 20 ++
 rtl/mips_tb_run_monitor.sv | 149 ++++++++++++++
 tb/tb_mips_tb_run_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the MIPS bench-side run monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_tb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DONE    = 3'd2,
    TIMEOUT = 3'd3,
    FAULT   = 3'd4
  } monitor_state_t;

  // First fetch address of the CPU after reset.
  localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;
  // Fetch address the CPU parks on once it has halted (jr $0).
  localparam logic [31:0] MIPS_HALT_ADDR    = 32'h00000000;

  // Terminal states never leave except through reset.
  function automatic logic is_terminal(input monitor_state_t s);
    return (s == DONE) || (s == TIMEOUT) || (s == FAULT);
  endfunction

endpackage

// File: rtl/mips_tb_sat_counter.sv
// 32-bit up counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an enabled edge immediately after that edge.
// Backpressure: none; holds whenever en is low.
module mips_tb_sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  // Synchronous clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 32'd0;
    end else if (en && (count != 32'hFFFFFFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mips_tb_run_monitor.sv
// Tracks a CPU run from reset vector to halt, with watchdog and v0 verdict.
// Latency: every output registered, visible right after the triggering enabled edge.
// Backpressure: clk_enable low freezes state and counters. Optional trace: MIPS_TB_MONITOR_TRACE_EN.
module mips_tb_run_monitor
  import mips_tb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] RESET_VECTOR   = MIPS_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr_address,
  input  logic [31:0] register_v0,
  input  logic [31:0] expected_v0,
  input  logic        expected_valid,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        fault,
  output logic [31:0] final_v0,
  output logic [31:0] cycle_count,
  output logic [31:0] fetch_count
);

  // Value cycle_count holds on the last RUN cycle before the watchdog fires.
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  monitor_state_t state, state_nxt;
  logic [31:0]    prev_addr;
  logic           done_nxt, pass_nxt, timeout_nxt, fault_nxt;
  logic [31:0]    final_nxt;
  logic           cyc_en, fetch_en;

  // Next state, next registered outputs and counter enables.
  always_comb begin
    state_nxt   = state;
    done_nxt    = done;
    pass_nxt    = pass;
    timeout_nxt = timeout;
    fault_nxt   = fault;
    final_nxt   = final_v0;
    cyc_en      = 1'b0;
    fetch_en    = 1'b0;
    if (clk_enable) begin
      case (state)
        IDLE: begin
          if (active) begin
            if (instr_address == RESET_VECTOR) begin
              // The launching edge is counted as cycle 1.
              state_nxt = RUN;
              cyc_en    = 1'b1;
            end else begin
              state_nxt = FAULT;
              fault_nxt = 1'b1;
              done_nxt  = 1'b1;
            end
          end
        end
        RUN: begin
          cyc_en   = 1'b1;
          fetch_en = (instr_address != prev_addr);
          // Halt is checked first so it wins over a coincident watchdog.
          if (!active) begin
            if (instr_address == MIPS_HALT_ADDR) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
              final_nxt = register_v0;
              pass_nxt  = !expected_valid || (register_v0 == expected_v0);
            end else begin
              state_nxt = FAULT;
              fault_nxt = 1'b1;
              done_nxt  = 1'b1;
            end
          end else if (cycle_count == TIMEOUT_LAST) begin
            state_nxt   = TIMEOUT;
            timeout_nxt = 1'b1;
            done_nxt    = 1'b1;
          end
        end
        default: begin
          // Terminal states hold until reset.
        end
      endcase
    end
  end

  // State and verdict registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      fault    <= 1'b0;
      final_v0 <= 32'd0;
    end else begin
      state    <= state_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      timeout  <= timeout_nxt;
      fault    <= fault_nxt;
      final_v0 <= final_nxt;
    end
  end

  // Previous fetch address, tracked while a run can be starting or in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_addr <= 32'd0;
    end else if (clk_enable && ((state == IDLE) || (state == RUN))) begin
      prev_addr <= instr_address;
    end
  end

  mips_tb_sat_counter u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cyc_en),
    .count (cycle_count)
  );

  mips_tb_sat_counter u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (fetch_en),
    .count (fetch_count)
  );

`ifdef MIPS_TB_MONITOR_TRACE_EN
  // Per-cycle fetch trace and end-of-run report for standalone directed tests.
  always @(posedge clk) begin
    if (!reset && clk_enable) begin
      if (state == RUN) begin
        $display("RUN : addr=%h cycle=%0d", instr_address, cycle_count + 32'd1);
      end
      if ((state_nxt != state) && is_terminal(state_nxt)) begin
        $display("CPU : OUT :%0d", final_nxt);
        $display("TB : Finished : %s", state_nxt.name());
        $finish;
      end
    end
  end
`else
  // No trace: the enclosing bench polls done.
`endif

endmodule

// File: tb/tb_mips_tb_run_monitor.sv
module tb_mips_tb_run_monitor;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] instr_address;
  logic [31:0] register_v0;
  logic [31:0] expected_v0;
  logic        expected_valid;
  logic        done, pass, timeout, fault;
  logic [31:0] final_v0, cycle_count, fetch_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_tb_run_monitor #(
    .TIMEOUT_CYCLES (20),
    .RESET_VECTOR   (RV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .instr_address  (instr_address),
    .register_v0    (register_v0),
    .expected_v0    (expected_v0),
    .expected_valid (expected_valid),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .fault          (fault),
    .final_v0       (final_v0),
    .cycle_count    (cycle_count),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge with the currently driven inputs; outputs settle by #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_enable = 1'b1; active = 1'b0; instr_address = 32'd0;
    register_v0 = 32'd0;
    step();
    reset = 1'b0;
  endtask

  task automatic start_run();
    active = 1'b1; instr_address = RV;
    step();
  endtask

  // Fetches RV+4, RV+8, RV+C, then halts with v0 = 0xC.
  task automatic short_program(input logic [31:0] exp_v0, input logic exp_vld);
    start_run();
    for (int i = 1; i <= 3; i++) begin
      instr_address = RV + 32'(4 * i);
      step();
    end
    active = 1'b0; instr_address = 32'd0; register_v0 = 32'h0000000C;
    expected_v0 = exp_v0; expected_valid = exp_vld;
    step();
  endtask

  initial begin
    expected_v0 = 32'd0; expected_valid = 1'b0;
    do_reset();
    reset = 1'b1; step(); reset = 1'b0;

    // Reset state
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_final", final_v0, 32'd0);
    chk("rst_cyc", cycle_count, 32'd0);
    chk("rst_fetch", fetch_count, 32'd0);

    // Idle with active low: nothing happens
    step();
    chk("idle_done", {31'd0, done}, 32'd0);

    // Normal halt
    start_run();
    chk("run_start_cyc", cycle_count, 32'd1);
    chk("run_start_done", {31'd0, done}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      instr_address = RV + 32'(4 * i);
      step();
    end
    chk("run_mid_fetch", fetch_count, 32'd3);
    active = 1'b0; instr_address = 32'd0; register_v0 = 32'h0000000C;
    expected_v0 = 32'h0000000C; expected_valid = 1'b1;
    step();
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_pass", {31'd0, pass}, 32'd1);
    chk("halt_final", final_v0, 32'h0000000C);
    chk("halt_fetch", fetch_count, 32'd4);
    chk("halt_cyc", cycle_count, 32'd5);
    chk("halt_timeout", {31'd0, timeout}, 32'd0);
    chk("halt_fault", {31'd0, fault}, 32'd0);
    // Terminal state holds even when inputs move
    register_v0 = 32'h12345678; active = 1'b1; instr_address = RV;
    step();
    chk("hold_final", final_v0, 32'h0000000C);
    chk("hold_cyc", cycle_count, 32'd5);
    chk("hold_done", {31'd0, done}, 32'd1);

    // Mismatch
    do_reset();
    chk("mm_rst_done", {31'd0, done}, 32'd0);
    short_program(32'h0000000D, 1'b1);
    chk("mm_done", {31'd0, done}, 32'd1);
    chk("mm_pass", {31'd0, pass}, 32'd0);
    chk("mm_final", final_v0, 32'h0000000C);

    // No golden value: clean halt alone passes
    do_reset();
    short_program(32'h0000000D, 1'b0);
    chk("nogold_pass", {31'd0, pass}, 32'd1);

    // Timeout (TIMEOUT_CYCLES = 20)
    do_reset();
    start_run();
    for (int i = 1; i <= 18; i++) begin
      instr_address = (i % 2 == 1) ? RV + 32'd4 : RV + 32'd8;
      step();
    end
    chk("to_pre_cyc", cycle_count, 32'd19);
    chk("to_pre_timeout", {31'd0, timeout}, 32'd0);
    instr_address = RV + 32'd4;
    step();
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_pass", {31'd0, pass}, 32'd0);
    chk("to_cyc", cycle_count, 32'd20);
    chk("to_final", final_v0, 32'd0);
    step();
    chk("to_hold_cyc", cycle_count, 32'd20);

    // Fault: bad first fetch
    do_reset();
    active = 1'b1; instr_address = 32'h00000040;
    step();
    chk("bf_fault", {31'd0, fault}, 32'd1);
    chk("bf_done", {31'd0, done}, 32'd1);
    chk("bf_pass", {31'd0, pass}, 32'd0);
    chk("bf_timeout", {31'd0, timeout}, 32'd0);
    chk("bf_cyc", cycle_count, 32'd0);

    // Fault: active falls away from the halt address
    do_reset();
    start_run();
    active = 1'b0; instr_address = RV + 32'd4;
    step();
    chk("af_fault", {31'd0, fault}, 32'd1);
    chk("af_done", {31'd0, done}, 32'd1);

    // Stall then reset then rerun
    do_reset();
    start_run();
    instr_address = RV + 32'd4;
    step();
    chk("st_pre_cyc", cycle_count, 32'd2);
    clk_enable = 1'b0;
    active = 1'b0; instr_address = 32'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_frozen_cyc", cycle_count, 32'd2);
    end
    chk("st_done", {31'd0, done}, 32'd0);
    chk("st_fetch", fetch_count, 32'd1);
    clk_enable = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sr_cyc", cycle_count, 32'd0);
    chk("sr_fetch", fetch_count, 32'd0);
    chk("sr_done", {31'd0, done}, 32'd0);
    short_program(32'h0000000C, 1'b1);
    chk("rerun_pass", {31'd0, pass}, 32'd1);
    chk("rerun_done", {31'd0, done}, 32'd1);

    // Halt on the same edge the watchdog would fire
    do_reset();
    start_run();
    for (int i = 1; i <= 18; i++) begin
      instr_address = (i % 2 == 1) ? RV + 32'd4 : RV + 32'd8;
      step();
    end
    active = 1'b0; instr_address = 32'd0; register_v0 = 32'h0000000C;
    expected_v0 = 32'h0000000C; expected_valid = 1'b1;
    step();
    chk("sim_done", {31'd0, done}, 32'd1);
    chk("sim_timeout", {31'd0, timeout}, 32'd0);
    chk("sim_pass", {31'd0, pass}, 32'd1);
    chk("sim_cyc", cycle_count, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
